// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus among REQUESTERS masters.
// Optional watchdog enabled by defining RGGEN_BUS_ARBITER_TIMEOUT_EN.
module rggen_bus_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [REQUESTERS-1:0]                 i_valid,
  input  logic [2*REQUESTERS-1:0]               i_access,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]   i_address,
  input  logic [BUS_WIDTH*REQUESTERS-1:0]       i_write_data,
  input  logic [BUS_WIDTH/8*REQUESTERS-1:0]     i_strobe,
  output logic [REQUESTERS-1:0]                 o_ready,
  output logic [2*REQUESTERS-1:0]               o_status,
  output logic [BUS_WIDTH*REQUESTERS-1:0]       o_read_data,
  output logic                                  o_bus_valid,
  output logic [1:0]                            o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]              o_bus_address,
  output logic [BUS_WIDTH-1:0]                  o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]                o_bus_strobe,
  input  logic                                  i_bus_ready,
  input  logic [1:0]                            i_bus_status,
  input  logic [BUS_WIDTH-1:0]                  i_bus_read_data
);
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int SW = BUS_WIDTH / 8;
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic                     state_reg;
  logic [IW-1:0]            ptr_reg;
  logic [IW-1:0]            grant_reg;
  logic [1:0]               access_reg;
  logic [ADDRESS_WIDTH-1:0] address_reg;
  logic [BUS_WIDTH-1:0]     write_data_reg;
  logic [SW-1:0]            strobe_reg;

  logic                     found;
  logic [IW-1:0]            sel;
  logic [1:0]               sel_access;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [BUS_WIDTH-1:0]     sel_write_data;
  logic [SW-1:0]            sel_strobe;
  logic                     timeout_hit;
  logic                     complete;
  logic [IW-1:0]            next_ptr;
  logic [1:0]               resp_status;
  logic [BUS_WIDTH-1:0]     resp_data;

  // Two passes give the wrap-around search: indices at/above the pointer first, then below it.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (!found && i_valid[j] && (IW'(j) >= ptr_reg)) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
    for (int j = 0; j < REQUESTERS; j++) begin
      if (!found && i_valid[j] && (IW'(j) < ptr_reg)) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_comb begin
    sel_access     = '0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (IW'(j) == sel) begin
        sel_access     = i_access[2*j +: 2];
        sel_address    = i_address[ADDRESS_WIDTH*j +: ADDRESS_WIDTH];
        sel_write_data = i_write_data[BUS_WIDTH*j +: BUS_WIDTH];
        sel_strobe     = i_strobe[SW*j +: SW];
      end
    end
  end

  assign complete = (state_reg == BUSY) && (i_bus_ready || timeout_hit);
  assign next_ptr = (grant_reg == IW'(REQUESTERS - 1)) ? '0 : grant_reg + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      grant_reg      <= '0;
      access_reg     <= '0;
      address_reg    <= '0;
      write_data_reg <= '0;
      strobe_reg     <= '0;
    end else if (state_reg == IDLE) begin
      if (found) begin
        state_reg      <= BUSY;
        grant_reg      <= sel;
        access_reg     <= sel_access;
        address_reg    <= sel_address;
        write_data_reg <= sel_write_data;
        strobe_reg     <= sel_strobe;
      end
    end else if (complete) begin
      state_reg <= IDLE;
      ptr_reg   <= next_ptr;
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count_reg;

  assign timeout_hit = (state_reg == BUSY) && !i_bus_ready &&
                       (count_reg == CW'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle so every access starts counting from its first BUSY cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state_reg == IDLE)) begin
      count_reg <= '0;
    end else if (!i_bus_ready) begin
      count_reg <= count_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  if ((REQUESTERS < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("rggen_bus_arbiter: REQUESTERS and TIMEOUT_CYCLES must be >= 1");
  end

  assign resp_status = timeout_hit ? 2'b10 : i_bus_status;
  assign resp_data   = timeout_hit ? '0 : i_bus_read_data;

  assign o_bus_valid      = (state_reg == BUSY);
  assign o_bus_access     = access_reg;
  assign o_bus_address    = address_reg;
  assign o_bus_write_data = write_data_reg;
  assign o_bus_strobe     = strobe_reg;

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_resp
    logic hit;
    assign hit                                = complete && (grant_reg == IW'(gi));
    assign o_ready[gi]                        = hit;
    assign o_status[2*gi +: 2]                = hit ? resp_status : 2'b00;
    assign o_read_data[BUS_WIDTH*gi +: BUS_WIDTH] = hit ? resp_data : '0;
  end
endmodule
